// File: rtl/pipe_hazard_track_if.sv
// rtl/pipe_hazard_track_if.sv - decode inputs, hazard controls and tracking outputs of pipe_hazard_track
interface pipe_hazard_track_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] RA1D;
    logic [ADDR_W-1:0] RA2D;
    logic [ADDR_W-1:0] WA3D;
    logic              RegWriteD;
    logic              MemtoRegD;
    logic              PCSrcD;
    logic              CondExE;
    logic              BranchTakenE;
    logic              StallD;
    logic              FlushE;
    logic              CntClr;
    logic              Match_1E_M;
    logic              Match_1E_W;
    logic              Match_2E_M;
    logic              Match_2E_W;
    logic              Match_12D_E;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              MemtoRegE;
    logic              PCSrcW;
    logic              PCWrPendingF;
    logic [CNT_W-1:0]  LoadStallCnt;
    logic [CNT_W-1:0]  BranchFlushCnt;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE,
               BranchTakenE, StallD, FlushE, CntClr,
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
               RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF,
               LoadStallCnt, BranchFlushCnt
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE,
               BranchTakenE, StallD, FlushE, CntClr,
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
               RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF,
               LoadStallCnt, BranchFlushCnt
    );
endinterface

// File: rtl/pipe_hazard_track.sv
// rtl/pipe_hazard_track.sv - register-address/control tracking through D/E/M/W for the hazard unit
module pipe_hazard_track #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                reset_n,
    pipe_hazard_track_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    logic              reg_write_e, reg_write_m, reg_write_w;
    logic              mem_to_reg_e;
    logic              pc_src_e, pc_src_m, pc_src_w;
    logic [CNT_W-1:0]  load_stall_cnt, branch_flush_cnt;

    // Stalls always come paired with FlushE, so the D/E register never holds; a flush loads a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ra1_e        <= '0;
            ra2_e        <= '0;
            wa3_e        <= '0;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            pc_src_e     <= 1'b0;
        end else if (bus.FlushE) begin
            ra1_e        <= '0;
            ra2_e        <= '0;
            wa3_e        <= '0;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            pc_src_e     <= 1'b0;
        end else begin
            ra1_e        <= bus.RA1D;
            ra2_e        <= bus.RA2D;
            wa3_e        <= bus.WA3D;
            reg_write_e  <= bus.RegWriteD;
            mem_to_reg_e <= bus.MemtoRegD;
            pc_src_e     <= bus.PCSrcD;
        end
    end

    // A failed condition kills the write enables only as they leave Execute.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wa3_m       <= '0;
            reg_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
            wa3_w       <= '0;
            reg_write_w <= 1'b0;
            pc_src_w    <= 1'b0;
        end else begin
            wa3_m       <= wa3_e;
            reg_write_m <= reg_write_e & bus.CondExE;
            pc_src_m    <= pc_src_e & bus.CondExE;
            wa3_w       <= wa3_m;
            reg_write_w <= reg_write_m;
            pc_src_w    <= pc_src_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_stall_cnt   <= '0;
            branch_flush_cnt <= '0;
        end else if (bus.CntClr) begin
            load_stall_cnt   <= '0;
            branch_flush_cnt <= '0;
        end else begin
            if (bus.StallD && load_stall_cnt != CNT_MAX)
                load_stall_cnt <= load_stall_cnt + CNT_ONE;
            if (bus.BranchTakenE && branch_flush_cnt != CNT_MAX)
                branch_flush_cnt <= branch_flush_cnt + CNT_ONE;
        end
    end

    assign bus.Match_1E_M     = (ra1_e == wa3_m);
    assign bus.Match_1E_W     = (ra1_e == wa3_w);
    assign bus.Match_2E_M     = (ra2_e == wa3_m);
    assign bus.Match_2E_W     = (ra2_e == wa3_w);
    assign bus.Match_12D_E    = (bus.RA1D == wa3_e) | (bus.RA2D == wa3_e);
    assign bus.RegWriteM      = reg_write_m;
    assign bus.RegWriteW      = reg_write_w;
    assign bus.MemtoRegE      = mem_to_reg_e;
    assign bus.PCSrcW         = pc_src_w;
    assign bus.PCWrPendingF   = bus.PCSrcD | (pc_src_e & bus.CondExE) | pc_src_m;
    assign bus.LoadStallCnt   = load_stall_cnt;
    assign bus.BranchFlushCnt = branch_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_track.sv
// tb/tb_pipe_hazard_track.sv - directed self-checking bench for pipe_hazard_track
module tb_pipe_hazard_track;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    pipe_hazard_track_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_track #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.RA1D = '0; bus.RA2D = '0; bus.WA3D = '0;
        bus.RegWriteD = 1'b0; bus.MemtoRegD = 1'b0; bus.PCSrcD = 1'b0;
        bus.CondExE = 1'b1; bus.BranchTakenE = 1'b0;
        bus.StallD = 1'b0; bus.FlushE = 1'b0; bus.CntClr = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.RA1D = 4'd2; bus.RA2D = 4'd3; bus.PCSrcD = 1'b1;
        reset_n = 1'b0;
        repeat (2) step();
        n_tests++; if (bus.Match_1E_M !== 1'b1) begin n_fail++; $display("FAIL reset_m1em got %b want 1", bus.Match_1E_M); end
        n_tests++; if ({bus.Match_1E_W, bus.Match_2E_M, bus.Match_2E_W} !== 3'b111) begin n_fail++; $display("FAIL reset_matches got %b want 111", {bus.Match_1E_W, bus.Match_2E_M, bus.Match_2E_W}); end
        n_tests++; if (bus.Match_12D_E !== 1'b0) begin n_fail++; $display("FAIL reset_m12de_nz got %b want 0", bus.Match_12D_E); end
        bus.RA2D = 4'd0; #1;
        n_tests++; if (bus.Match_12D_E !== 1'b1) begin n_fail++; $display("FAIL reset_m12de_z got %b want 1", bus.Match_12D_E); end
        n_tests++; if ({bus.RegWriteM, bus.RegWriteW, bus.MemtoRegE, bus.PCSrcW} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {bus.RegWriteM, bus.RegWriteW, bus.MemtoRegE, bus.PCSrcW}); end
        n_tests++; if (bus.PCWrPendingF !== 1'b1) begin n_fail++; $display("FAIL reset_pcwr got %b want 1", bus.PCWrPendingF); end
        n_tests++; if (bus.LoadStallCnt !== 16'd0 || bus.BranchFlushCnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.LoadStallCnt, bus.BranchFlushCnt); end
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        drain();
        bus.WA3D = 4'd3; bus.RegWriteD = 1'b1;
        step();
        bus.WA3D = 4'd7; bus.RegWriteD = 1'b0; bus.RA1D = 4'd3; bus.CondExE = 1'b1;
        step();
        n_tests++; if (bus.Match_1E_M !== 1'b1) begin n_fail++; $display("FAIL b2b_m1em got %b want 1", bus.Match_1E_M); end
        n_tests++; if (bus.RegWriteM !== 1'b1) begin n_fail++; $display("FAIL b2b_rwm got %b want 1", bus.RegWriteM); end
        n_tests++; if (bus.Match_2E_M !== 1'b0) begin n_fail++; $display("FAIL b2b_m2em got %b want 0", bus.Match_2E_M); end
        bus.WA3D = 4'd0;
        step();
        n_tests++; if (bus.Match_1E_W !== 1'b1) begin n_fail++; $display("FAIL b2b_m1ew got %b want 1", bus.Match_1E_W); end
        n_tests++; if (bus.RegWriteW !== 1'b1) begin n_fail++; $display("FAIL b2b_rww got %b want 1", bus.RegWriteW); end
        n_tests++; if (bus.Match_1E_M !== 1'b0) begin n_fail++; $display("FAIL b2b_m1em_next got %b want 0", bus.Match_1E_M); end
        n_tests++; if (bus.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL b2b_rwm_next got %b want 0", bus.RegWriteM); end
    endtask

    task automatic test_load_use();
        drain();
        bus.MemtoRegD = 1'b1; bus.RegWriteD = 1'b1; bus.WA3D = 4'd5;
        step();
        bus.MemtoRegD = 1'b0; bus.RegWriteD = 1'b0; bus.WA3D = 4'd2;
        bus.RA1D = 4'd1; bus.RA2D = 4'd5;
        #1;
        n_tests++; if (bus.Match_12D_E !== 1'b1) begin n_fail++; $display("FAIL lu_m12de got %b want 1", bus.Match_12D_E); end
        n_tests++; if (bus.MemtoRegE !== 1'b1) begin n_fail++; $display("FAIL lu_m2re got %b want 1", bus.MemtoRegE); end
        bus.StallD = 1'b1; bus.FlushE = 1'b1;
        step();
        bus.StallD = 1'b0; bus.FlushE = 1'b0;
        #1;
        n_tests++; if (bus.MemtoRegE !== 1'b0) begin n_fail++; $display("FAIL lu_m2re_bubble got %b want 0", bus.MemtoRegE); end
        n_tests++; if (bus.LoadStallCnt !== 16'd1) begin n_fail++; $display("FAIL lu_stallcnt got %0d want 1", bus.LoadStallCnt); end
        n_tests++; if (bus.RegWriteM !== 1'b1) begin n_fail++; $display("FAIL lu_rwm_load got %b want 1", bus.RegWriteM); end
        n_tests++; if (bus.Match_12D_E !== 1'b0) begin n_fail++; $display("FAIL lu_m12de_bubble got %b want 0", bus.Match_12D_E); end
        step();
        n_tests++; if (bus.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL lu_rwm_bubble got %b want 0", bus.RegWriteM); end
    endtask

    task automatic test_pc_write();
        drain();
        bus.PCSrcD = 1'b1; #1;
        n_tests++; if (bus.PCWrPendingF !== 1'b1) begin n_fail++; $display("FAIL pc_pend_d got %b want 1", bus.PCWrPendingF); end
        step();
        bus.PCSrcD = 1'b0; #1;
        n_tests++; if (bus.PCWrPendingF !== 1'b1) begin n_fail++; $display("FAIL pc_pend_e got %b want 1", bus.PCWrPendingF); end
        step();
        n_tests++; if (bus.PCWrPendingF !== 1'b1 || bus.PCSrcW !== 1'b0) begin n_fail++; $display("FAIL pc_pend_m got %b/%b want 1/0", bus.PCWrPendingF, bus.PCSrcW); end
        step();
        n_tests++; if (bus.PCWrPendingF !== 1'b0 || bus.PCSrcW !== 1'b1) begin n_fail++; $display("FAIL pc_w got %b/%b want 0/1", bus.PCWrPendingF, bus.PCSrcW); end
        step();
        n_tests++; if (bus.PCSrcW !== 1'b0) begin n_fail++; $display("FAIL pc_w_drop got %b want 0", bus.PCSrcW); end
    endtask

    task automatic test_cond_fail();
        drain();
        bus.PCSrcD = 1'b1; bus.RegWriteD = 1'b1; bus.MemtoRegD = 1'b1; bus.CondExE = 1'b0; #1;
        n_tests++; if (bus.PCWrPendingF !== 1'b1) begin n_fail++; $display("FAIL cf_pend_d got %b want 1", bus.PCWrPendingF); end
        step();
        bus.PCSrcD = 1'b0; bus.RegWriteD = 1'b0; bus.MemtoRegD = 1'b0; #1;
        n_tests++; if (bus.PCWrPendingF !== 1'b0) begin n_fail++; $display("FAIL cf_pend_e got %b want 0", bus.PCWrPendingF); end
        n_tests++; if (bus.MemtoRegE !== 1'b1) begin n_fail++; $display("FAIL cf_m2re got %b want 1", bus.MemtoRegE); end
        step();
        n_tests++; if (bus.RegWriteM !== 1'b0 || bus.PCWrPendingF !== 1'b0) begin n_fail++; $display("FAIL cf_m got %b/%b want 0/0", bus.RegWriteM, bus.PCWrPendingF); end
        step();
        n_tests++; if (bus.PCSrcW !== 1'b0 || bus.RegWriteW !== 1'b0) begin n_fail++; $display("FAIL cf_w got %b/%b want 0/0", bus.PCSrcW, bus.RegWriteW); end
    endtask

    task automatic test_flush_wins();
        drain();
        bus.WA3D = 4'd9; bus.RegWriteD = 1'b1; bus.PCSrcD = 1'b1; bus.MemtoRegD = 1'b1; bus.FlushE = 1'b1;
        step();
        idle_inputs();
        bus.RA1D = 4'd9; bus.RA2D = 4'd9; #1;
        n_tests++; if (bus.PCWrPendingF !== 1'b0) begin n_fail++; $display("FAIL fl_pend got %b want 0", bus.PCWrPendingF); end
        n_tests++; if (bus.Match_12D_E !== 1'b0 || bus.MemtoRegE !== 1'b0) begin n_fail++; $display("FAIL fl_e got %b/%b want 0/0", bus.Match_12D_E, bus.MemtoRegE); end
        step();
        n_tests++; if (bus.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL fl_rwm got %b want 0", bus.RegWriteM); end
    endtask

    task automatic test_counters();
        drain();
        bus.BranchTakenE = 1'b1;
        repeat (3) step();
        n_tests++; if (bus.BranchFlushCnt !== 16'd3) begin n_fail++; $display("FAIL cnt_three got %0d want 3", bus.BranchFlushCnt); end
        repeat ((1 << CNT_W) + 2) step();
        n_tests++; if (bus.BranchFlushCnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat got %0d want 65535", bus.BranchFlushCnt); end
        n_tests++; if (bus.LoadStallCnt !== 16'd1) begin n_fail++; $display("FAIL cnt_stall_hold got %0d want 1", bus.LoadStallCnt); end
        bus.CntClr = 1'b1; bus.StallD = 1'b1; bus.FlushE = 1'b1;
        step();
        n_tests++; if (bus.BranchFlushCnt !== 16'd0 || bus.LoadStallCnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clr got %0d/%0d want 0/0", bus.BranchFlushCnt, bus.LoadStallCnt); end
        bus.CntClr = 1'b0;
        step();
        n_tests++; if (bus.BranchFlushCnt !== 16'd1 || bus.LoadStallCnt !== 16'd1) begin n_fail++; $display("FAIL cnt_after_clr got %0d/%0d want 1/1", bus.BranchFlushCnt, bus.LoadStallCnt); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        drain();
        bus.RegWriteD = 1'b1; bus.PCSrcD = 1'b1; bus.BranchTakenE = 1'b1;
        step();
        bus.RegWriteD = 1'b0; bus.PCSrcD = 1'b0;
        step();
        n_tests++; if (bus.RegWriteM !== 1'b1 || bus.BranchFlushCnt === 16'd0) begin n_fail++; $display("FAIL ar_pre got %b/%0d want 1/nonzero", bus.RegWriteM, bus.BranchFlushCnt); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.RegWriteM !== 1'b0 || bus.PCWrPendingF !== 1'b0) begin n_fail++; $display("FAIL ar_ctrl got %b/%b want 0/0", bus.RegWriteM, bus.PCWrPendingF); end
        n_tests++; if (bus.BranchFlushCnt !== 16'd0 || bus.LoadStallCnt !== 16'd0) begin n_fail++; $display("FAIL ar_cnt got %0d/%0d want 0/0", bus.BranchFlushCnt, bus.LoadStallCnt); end
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_tests++; if (bus.RegWriteW !== 1'b0 || bus.PCSrcW !== 1'b0) begin n_fail++; $display("FAIL ar_after got %b/%b want 0/0", bus.RegWriteW, bus.PCSrcW); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_pc_write();
        test_cond_fail();
        test_flush_wins();
        test_counters();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_track.md
# pipe_hazard_track

Pipeline-side companion to the hazard unit: carries register addresses and hazard-relevant control bits through the Decode→Execute→Memory→Writeback registers and produces the match and pending-write signals the hazard unit consumes. It also obeys the hazard unit's Execute-stage flush when loading its Decode/Execute register. It sits beside the datapath pipeline registers and also keeps saturating counters of stall and flush events for performance debug.

## Interface

- ADDR_W, 4, register-address width
- CNT_W, 16, width of each event counter

- clk  in  1  pipeline clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- RA1D, RA2D  in  ADDR_W  source register addresses of the instruction in Decode
- WA3D  in  ADDR_W  destination register address in Decode
- RegWriteD, MemtoRegD, PCSrcD  in  1 each  decoded controls in Decode
- CondExE  in  1  condition-check result for the instruction in Execute
- BranchTakenE  in  1  branch resolved taken in Execute (counted only)
- StallD, FlushE  in  1 each  from hazard unit
- CntClr  in  1  synchronous clear of both counters
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  out  1 each  Execute source vs Memory/Writeback destination equality
- Match_12D_E  out  1  either Decode source equals Execute destination
- RegWriteM, RegWriteW, MemtoRegE, PCSrcW  out  1 each  stage control bits
- PCWrPendingF  out  1  a PC write is in flight in Decode, Execute or Memory
- LoadStallCnt, BranchFlushCnt  out  CNT_W each  event counters

## Operation

- Internal registers: RA1E, RA2E, WA3E, WA3M, WA3W (ADDR_W); RegWriteE/M/W, MemtoRegE, PCSrcE/M/W (1 bit).
- D/E register, every edge: if FlushE, RegWriteE, MemtoRegE and PCSrcE are loaded with 0, and RA1E, RA2E and WA3E are loaded with 0. Otherwise all E registers load their D-stage inputs.
- StallD is not used to hold the D/E register. The hazard unit always pairs StallD with FlushE, so stalls insert a bubble.
- E/M register, every edge, no stall or flush:
  - RegWriteM ← RegWriteE & CondExE
  - PCSrcM ← PCSrcE & CondExE
  - WA3M ← WA3E
- M/W register, every edge: RegWriteW ← RegWriteM, PCSrcW ← PCSrcM, WA3W ← WA3M.
- Combinational outputs:
  - Match_1E_M = (RA1E == WA3M)
  - Match_1E_W = (RA1E == WA3W)
  - Match_2E_M and Match_2E_W use RA2E in the same way.
  - Match_12D_E = (RA1D == WA3E) | (RA2D == WA3E)
  - PCWrPendingF = PCSrcD | (PCSrcE & CondExE) | PCSrcM
- Matches are raw address compares and are not gated by write enables. The hazard unit gates them with RegWriteM/W and MemtoRegE.
- LoadStallCnt increments on an edge where StallD = 1.
- BranchFlushCnt increments on an edge where BranchTakenE = 1.
- Both counters saturate at 2^CNT_W−1, with no wrap.
- CntClr = 1 zeroes both counters and takes priority over an increment in the same cycle.

## Timing

- Reset (async assert, synchronous-to-clk deassert by the system) clears every register.
- Outputs in reset: all Match_* = 1 (0 == 0). Match_12D_E follows the D inputs. RegWriteM, RegWriteW, MemtoRegE and PCSrcW = 0. PCWrPendingF = PCSrcD. Counters = 0.
- Latency: a D-stage control appears in E after 1 edge, in M after 2 edges, in W after 3 edges.
- Outputs are combinational from registers and D inputs, with zero cycles of added latency.
- FlushE and a valid D instruction in the same cycle: the flush wins and the instruction is dropped from tracking.
- Reset mid-operation: all in-flight controls are discarded immediately, with no partial completion.
- CondExE = 0 kills RegWrite and PCSrc at the E→M transfer only. MemtoRegE is unaffected.

## Test plan

- Back-to-back dependence: WA3D = 3 with RegWriteD = 1, then next cycle RA1D = 3, CondExE = 1 → one edge later Match_1E_M = 1 and RegWriteM = 1; one more edge later Match_1E_W = 1 and RegWriteW = 1.
- Load-use: an LDR with MemtoRegD = 1 and WA3D = 5 moves to E; the next Decode has RA2D = 5 → Match_12D_E = 1 and MemtoRegE = 1. Driving StallD = FlushE = 1 for one edge yields MemtoRegE = 0, RegWriteE = 0 and LoadStallCnt = 1.
- PC write tracking: PCSrcD = 1 for one cycle with CondExE = 1 → PCWrPendingF = 1 for 3 consecutive cycles (D, E, M), then PCSrcW = 1 for 1 cycle.
- Condition fail: PCSrcD = 1 and RegWriteD = 1, with CondExE = 0 in E → PCWrPendingF drops after the D cycle, and RegWriteM = PCSrcW = 0.
- Counters: BranchTakenE held high for 2^CNT_W+5 cycles → BranchFlushCnt = 2^CNT_W−1. CntClr together with BranchTakenE → 0.
- Async reset: assert reset_n = 0 mid-cycle while RegWriteM = 1 → RegWriteM = 0 before the next clk edge, and counters = 0.
